// File: rtl/adc_clkgen_multi.sv
// N-channel divided clock / strobe generator with per-channel programmable divide
// ratio and phase, phase-aligned restart on apply, and a PLL-style locked flag.
module adc_clkgen_multi #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 25,
    parameter int LOCK_DLY    = 16,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LK_W = (LOCK_DLY > 0) ? $clog2(LOCK_DLY + 1) : 1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             cfg_apply,
    output logic             cfg_err,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  stb,
    output logic             locked
);

    localparam logic [1:0] ST_APPLY   = 2'd0;
    localparam logic [1:0] ST_LOCKING = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [LK_W-1:0]  lk_cnt, lk_nxt;
    logic [DIV_W-1:0] sh_div  [N_CH];
    logic [DIV_W-1:0] sh_ph   [N_CH];
    logic [DIV_W-1:0] act_div [N_CH];
    logic [DIV_W-1:0] act_ph  [N_CH];
    logic [DIV_W-1:0] cnt     [N_CH];
    logic [DIV_W-1:0] cnt_nxt [N_CH];
    logic [DIV_W-1:0] src_div [N_CH];
    logic [DIV_W-1:0] src_ph  [N_CH];
    logic [DIV_W-1:0] d_eff   [N_CH];
    logic [DIV_W-1:0] p_eff   [N_CH];
    logic [DIV_W-1:0] half    [N_CH];
    logic [N_CH-1:0]  en, seen, seen_nxt, clk_nxt, stb_nxt;
    logic             apply, wr_en, ch_bad, all_seen;

    assign cfg_ready = (state != ST_APPLY);
    assign locked    = (state == ST_LOCKED);

    always_comb begin
        apply = (state == ST_APPLY);
        wr_en = cfg_valid && cfg_ready;
        ch_bad = (int'(cfg_ch) >= N_CH);
        for (int unsigned i = 0; i < N_CH; i++) begin
            // In APPLY the shadow values are the ones about to become active.
            src_div[i] = apply ? sh_div[i] : act_div[i];
            src_ph[i]  = apply ? sh_ph[i]  : act_ph[i];
            en[i]      = |src_div[i];
            d_eff[i]   = (src_div[i] == DIV_W'(1)) ? DIV_W'(2) : src_div[i];
            p_eff[i]   = '0;
            if (en[i])
                p_eff[i] = (src_ph[i] > d_eff[i] - DIV_W'(1)) ? d_eff[i] - DIV_W'(1) : src_ph[i];
            half[i]    = (d_eff[i] >> 1) + {{(DIV_W-1){1'b0}}, d_eff[i][0]};
            cnt_nxt[i] = '0;
            if (en[i]) begin
                if (apply)
                    cnt_nxt[i] = (p_eff[i] == '0) ? '0 : d_eff[i] - p_eff[i];
                else
                    cnt_nxt[i] = (cnt[i] == d_eff[i] - DIV_W'(1)) ? '0 : cnt[i] + DIV_W'(1);
            end
            clk_nxt[i]  = en[i] && (cnt_nxt[i] < half[i]);
            stb_nxt[i]  = en[i] && (cnt_nxt[i] == '0);
            seen_nxt[i] = (seen[i] && !apply) || stb_nxt[i];
        end
        all_seen = &(seen_nxt | ~en);
        lk_nxt = '0;
        if (!apply)
            lk_nxt = (lk_cnt == LK_W'(LOCK_DLY)) ? lk_cnt : lk_cnt + LK_W'(1);
        // Transition uses next-cycle counter/flags so LOCKED coincides with lk_cnt==LOCK_DLY.
        state_nxt = state;
        case (state)
            ST_APPLY:   state_nxt = ST_LOCKING;
            ST_LOCKING: begin
                if (cfg_apply)
                    state_nxt = ST_APPLY;
                else if (lk_nxt == LK_W'(LOCK_DLY) && all_seen)
                    state_nxt = ST_LOCKED;
            end
            ST_LOCKED:  if (cfg_apply) state_nxt = ST_APPLY;
            default:    state_nxt = ST_APPLY;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state   <= ST_APPLY;
            lk_cnt  <= '0;
            seen    <= '0;
            clk_out <= '0;
            stb     <= '0;
            cfg_err <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                sh_div[i]  <= DIV_W'(DEFAULT_DIV);
                sh_ph[i]   <= '0;
                act_div[i] <= DIV_W'(DEFAULT_DIV);
                act_ph[i]  <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            state   <= state_nxt;
            lk_cnt  <= lk_nxt;
            seen    <= seen_nxt;
            clk_out <= clk_nxt;
            stb     <= stb_nxt;
            cfg_err <= wr_en && ch_bad;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (wr_en && !ch_bad && cfg_ch == CH_W'(i)) begin
                    sh_div[i] <= cfg_div;
                    sh_ph[i]  <= cfg_phase;
                end
                if (apply) begin
                    act_div[i] <= sh_div[i];
                    act_ph[i]  <= sh_ph[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_clkgen_multi.sv
// Directed bench for adc_clkgen_multi (3 channels so an out-of-range cfg_ch exists).
module tb_adc_clkgen_multi;

    logic       refclk = 1'b0;
    logic       rst_n, cfg_valid, cfg_ready, cfg_apply, cfg_err, locked;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div, cfg_phase;
    logic [2:0] clk_out, stb;

    int n_assert = 0;
    int n_fail   = 0;
    int md [3];
    int mp [3];

    adc_clkgen_multi #(.N_CH(3), .DIV_W(8), .DEFAULT_DIV(25), .LOCK_DLY(16)) dut (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_apply(cfg_apply),
        .cfg_err(cfg_err), .clk_out(clk_out), .stb(stb), .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {clk, stb} of a channel c cycles after the APPLY cycle (c=1 is the first).
    function automatic logic [1:0] model(input int dv, input int ph, input int c);
        int d, p, st, cn;
        d = (dv == 0) ? 0 : ((dv == 1) ? 2 : dv);
        if (d == 0) return 2'b00;
        p  = (ph > d - 1) ? d - 1 : ph;
        st = (d - p) % d;
        cn = (st + c - 1) % d;
        return {(cn < (d + 1) / 2), (cn == 0)};
    endfunction

    task automatic run(input int cmax);
        logic [2:0] es, ec;
        logic [1:0] m;
        for (int c = 1; c <= cmax; c++) begin
            if (c > 1) step();
            for (int i = 0; i < 3; i++) begin
                m = model(md[i], mp[i], c);
                ec[i] = m[1];
                es[i] = m[0];
            end
            chk($sformatf("c%0d stb", c), 32'(stb), 32'(es));
            chk($sformatf("c%0d clk_out", c), 32'(clk_out), 32'(ec));
            chk($sformatf("c%0d locked", c), 32'(locked), 32'(c >= 17));
            chk($sformatf("c%0d cfg_ready", c), 32'(cfg_ready), 32'd1);
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] ph,
                         input logic ap);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_phase = ph; cfg_apply = ap;
        step();
        cfg_valid = 1'b0; cfg_apply = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " clk_out"}, 32'(clk_out), 32'd0);
        chk({tag, " stb"}, 32'(stb), 32'd0);
        chk({tag, " locked"}, 32'(locked), 32'd0);
        chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_apply = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_phase = '0;

        // Reset and defaults
        step(); step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        md = '{25, 25, 25}; mp = '{0, 0, 0};
        run(26);

        // Out-of-range write, then ch1/ch2 shadow writes and apply
        write(2'd3, 8'd9, 8'd0, 1'b0);
        chk("err pulse", 32'(cfg_err), 32'd1);
        step();
        chk("err clear", 32'(cfg_err), 32'd0);
        write(2'd1, 8'd4, 8'd2, 1'b0);
        write(2'd2, 8'd0, 8'd0, 1'b0);
        chk("locked before apply", 32'(locked), 32'd1);
        cfg_apply = 1'b1;
        step();
        cfg_apply = 1'b0;
        chk("apply locked", 32'(locked), 32'd0);
        chk("apply cfg_ready", 32'(cfg_ready), 32'd0);
        step();
        md = '{25, 4, 0}; mp = '{0, 2, 0};
        run(17);

        // div=1 clamp, phase clamp, write+apply in the same cycle
        write(2'd0, 8'd1, 8'd0, 1'b0);
        write(2'd1, 8'd5, 8'd9, 1'b0);
        write(2'd2, 8'd7, 8'd3, 1'b1);
        chk("apply2 cfg_ready", 32'(cfg_ready), 32'd0);
        step();
        md = '{1, 5, 7}; mp = '{0, 9, 3};
        run(12);

        // Apply while LOCKING, with a second pulse during APPLY
        cfg_apply = 1'b1;
        step();
        chk("b2b apply cfg_ready", 32'(cfg_ready), 32'd0);
        step();
        cfg_apply = 1'b0;
        run(17);

        // Mid-run reset restores defaults
        rst_n = 1'b0;
        step();
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        step();
        md = '{25, 25, 25}; mp = '{0, 0, 0};
        run(17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
